writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Merges the single-cycle ALU result path with a long-latency load/store (LSU) result stream onto the register file's single write port (A3/WD3/WE3). The ALU always wins the port. LSU results wait in a small queue and drain on cycles the ALU leaves free. The block also reports per-register "write pending" status so decode can stall on reads of queued destinations.

## Interface
Parameters:
- DEPTH, 4, LSU queue entries; power of two, ≥2
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alu_we  in  1  ALU result valid this cycle
- alu_a3  in  AW  ALU destination register
- alu_wd  in  DW  ALU result
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  queue can accept; transfer when lsu_valid && lsu_ready at posedge
- lsu_a3  in  AW  LSU destination register
- lsu_wd  in  DW  LSU result
- q_a1, q_a2  in  AW  decode-stage source registers to check
- busy1, busy2  out  1  a valid queued entry targets q_a1 / q_a2
- WE3  out  1  register file write enable
- A3  out  AW  register file write address
- WD3  out  DW  register file write data

## Operation
- Port select, combinational, per cycle:
  - ALU write: alu_we && alu_a3≠0 → WE3=1, A3=alu_a3, WD3=alu_wd.
  - Otherwise the port is free. If the queue is non-empty, pop the head. The head drives WE3 only if its valid bit is set.
  - Otherwise WE3=0.
- Writes to register 0 are never emitted:
  - An ALU write to register 0 counts as "no ALU write", so the port is free.
  - An LSU transfer to register 0 is accepted (handshake completes) but not enqueued.
- WAW kill: an ALU write to r≠0 clears the valid bit of every queued entry with a3==r. In the same cycle, an incoming LSU transfer with a3==r is enqueued with valid=0. The ALU write is always treated as youngest.
- Killed entries still occupy slots. They are popped in order, one per free cycle, with WE3=0 on that cycle.
- Queue accepts at most one push and one pop per cycle; push and pop may occur in the same cycle.
- lsu_ready = (count < DEPTH). It depends on stored count only, so it is low when full even in a cycle that pops.
- busy1/busy2 are high when any stored valid entry has a3 == query address and the query address ≠ 0. The in-flight LSU input does not count.
- Queue wrap: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count has log2(DEPTH)+1 bits.

## Timing
- Reset values:
  - count=0, pointers=0, all entry valid bits=0.
  - lsu_ready=0 while reset is asserted, 1 on the first cycle after.
  - busy1/busy2=0.
  - WE3 follows alu_we/alu_a3 combinationally, and is 0 when the ALU is idle.
- Reset mid-operation discards all queued entries. Discarded entries are never written.
- ALU path: zero latency, combinational to WE3/A3/WD3.
- LSU path (macro off): accepted at edge N, written to the register file at the earliest edge N+1 if the port is free in cycle N+1.
- Sustained ALU writes stall the drain indefinitely. lsu_ready drops once DEPTH entries are stored.

## Configuration
WB_BYPASS_EN:
- Defined: when lsu_valid, the queue is empty, no ALU write is active and lsu_a3≠0, the LSU data drives WE3/A3/WD3 the same cycle and is not enqueued. lsu_ready is high, since count=0. Latency is 0.
- Undefined: every LSU transfer is enqueued. Minimum latency is 1 cycle.

## Structure
- Package wb_pkg: reg_addr_t [AW-1:0], word_t [DW-1:0], wb_entry_t {valid, a3, wd}, REG_ZERO constant.
- One sub-module, wb_entry_queue, holds the circular buffer and owns:
  - pointers and count
  - per-entry kill compare (kill_en, kill_a3)
  - match outputs for busy1/busy2
- The top level holds the port mux, zero-register filter and handshake.

## Test plan
- Reset, then idle cycles → WE3=0, lsu_ready=1, busy1=busy2=0.
- LSU push r5=0xDEAD_BEEF with ALU idle → busy(q=5)=1 for one cycle; the next cycle has WE3=1, A3=5, WD3=0xDEADBEEF; then busy=0. With WB_BYPASS_EN the write occurs in the same cycle and busy is never set.
- ALU writes r1..r8 on 8 consecutive cycles while the LSU pushes r10..r15 → lsu_ready=0 after 4 accepted; WE3 shows only ALU writes; then drain of r10..r13 in order, then r14, r15.
- Queue r7=0x11, then ALU writes r7=0x22 before the drain → the queued entry is killed; busy(q=7)=0; the pop cycle has WE3=0; r7 stays 0x22.
- LSU push to r0 and ALU write to r0 → the handshake completes, WE3 is never asserted with A3=0, and count stays 0.
- Full queue with reset asserted for one cycle → count=0 and no queued write ever appears on WE3 afterward.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter: address/data words and queued LSU entries.
package wb_pkg;

  localparam int unsigned WB_AW = 5;
  localparam int unsigned WB_DW = 32;

  typedef logic [WB_AW-1:0] reg_addr_t;
  typedef logic [WB_DW-1:0] word_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t a3;
    word_t     wd;
  } wb_entry_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/writeback_arbiter_if.sv
// ALU/LSU writeback sources, decode busy queries and the register-file write port.
interface writeback_arbiter_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          alu_we;
  logic [AW-1:0] alu_a3;
  logic [DW-1:0] alu_wd;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [AW-1:0] lsu_a3;
  logic [DW-1:0] lsu_wd;
  logic [AW-1:0] q_a1;
  logic [AW-1:0] q_a2;
  logic          busy1;
  logic          busy2;
  logic          WE3;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;

  modport master (
    output alu_we, alu_a3, alu_wd, lsu_valid, lsu_a3, lsu_wd, q_a1, q_a2,
    input  lsu_ready, busy1, busy2, WE3, A3, WD3
  );

  modport slave (
    input  alu_we, alu_a3, alu_wd, lsu_valid, lsu_a3, lsu_wd, q_a1, q_a2,
    output lsu_ready, busy1, busy2, WE3, A3, WD3
  );
endinterface

// File: rtl/wb_entry_queue.sv
// Circular buffer of pending LSU writebacks with per-entry WAW kill and destination match.
module wb_entry_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  wb_entry_t                i_push_entry,
  input  logic                     i_pop,
  input  logic                     i_kill_en,
  input  reg_addr_t                i_kill_a3,
  input  reg_addr_t                i_q_a1,
  input  reg_addr_t                i_q_a2,
  output wb_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_match1,
  output logic                     o_match2
);

  localparam int unsigned PW = $clog2(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW:0]     r_count;

  // Popped slots drop their valid bit so only stored entries ever report a match.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (i_kill_en && (r_mem[i].a3 == i_kill_a3)) begin
          r_mem[i].valid <= 1'b0;
        end
      end
      if (i_pop) begin
        r_mem[r_rptr].valid <= 1'b0;
        r_rptr              <= r_rptr + 1'b1;
      end
      if (i_push) begin
        r_mem[r_wptr] <= i_push_entry;
        r_wptr        <= r_wptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_match1 = 1'b0;
    o_match2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_mem[i].valid && (r_mem[i].a3 == i_q_a1) && (i_q_a1 != REG_ZERO)) o_match1 = 1'b1;
      if (r_mem[i].valid && (r_mem[i].a3 == i_q_a2) && (i_q_a2 != REG_ZERO)) o_match2 = 1'b1;
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: ALU has priority, LSU results queue and drain on free cycles.
// Optional macro WB_BYPASS_EN lets an LSU result write straight through when the queue is empty.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned DW    = WB_DW
) (
  input logic                clk,
  input logic                reset,
  writeback_arbiter_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];

  if ((AW != WB_AW) || (DW != WB_DW)) begin : g_width_check
    $error("writeback_arbiter: AW/DW must match wb_pkg widths");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("writeback_arbiter: DEPTH must be a power of two >= 2");
  end

  logic        w_alu_wr;
  logic        w_lsu_fire;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;
  wb_entry_t   w_push_entry;
  wb_entry_t   w_head;
  logic [PW:0] w_count;
  logic        w_empty;
  logic        w_match1;
  logic        w_match2;

  // An ALU write to r0 is no write at all, so the port stays free for the queue.
  assign w_alu_wr      = bus.alu_we && (bus.alu_a3 != REG_ZERO);
  assign bus.lsu_ready = !reset && (w_count < DEPTH_CNT);
  assign w_lsu_fire    = bus.lsu_valid && bus.lsu_ready;

`ifdef WB_BYPASS_EN
  assign w_bypass = w_lsu_fire && w_empty && !w_alu_wr && (bus.lsu_a3 != REG_ZERO);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_lsu_fire && (bus.lsu_a3 != REG_ZERO) && !w_bypass;
  assign w_pop  = !reset && !w_alu_wr && !w_empty;

  // A same-cycle ALU write to the same register is younger, so the incoming entry arrives dead.
  always_comb begin
    w_push_entry       = '0;
    w_push_entry.valid = !(w_alu_wr && (bus.lsu_a3 == bus.alu_a3));
    w_push_entry.a3    = bus.lsu_a3;
    w_push_entry.wd    = bus.lsu_wd;
  end

  wb_entry_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_kill_en    (w_alu_wr),
    .i_kill_a3    (bus.alu_a3),
    .i_q_a1       (bus.q_a1),
    .i_q_a2       (bus.q_a2),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_empty      (w_empty),
    .o_match1     (w_match1),
    .o_match2     (w_match2)
  );

  always_comb begin
    bus.WE3 = 1'b0;
    bus.A3  = '0;
    bus.WD3 = '0;
    if (w_alu_wr) begin
      bus.WE3 = 1'b1;
      bus.A3  = bus.alu_a3;
      bus.WD3 = bus.alu_wd;
    end else if (w_bypass) begin
      bus.WE3 = 1'b1;
      bus.A3  = bus.lsu_a3;
      bus.WD3 = bus.lsu_wd;
    end else if (w_pop) begin
      // Killed entries still consume their pop slot, with the write suppressed.
      bus.WE3 = w_head.valid;
      bus.A3  = w_head.a3;
      bus.WD3 = w_head.wd;
    end
  end

  assign bus.busy1 = w_match1;
  assign bus.busy2 = w_match2;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus random traffic vs a queue model.
module tb_writeback_arbiter;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  writeback_arbiter_if #(.AW(5), .DW(32)) bus ();

  writeback_arbiter #(
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          valid;
    int unsigned a3;
    int unsigned wd;
  } m_entry_t;

  m_entry_t    m_q[$];
  int unsigned m_rf[32];
  int unsigned dut_rf[32];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check outputs mid-cycle against the model, then advance the model.
  task automatic step(input bit rst, input bit awe, input int unsigned aa3, input int unsigned awd,
                      input bit lv, input int unsigned la3, input int unsigned lwd,
                      input int unsigned qa1, input int unsigned qa2, output bit accepted);
    bit          alu_wr, ready, bypass, pop, e_we, b1, b2;
    int unsigned e_a3, e_wd;
    reset         = rst;
    bus.alu_we    = awe;
    bus.alu_a3    = 5'(aa3);
    bus.alu_wd    = awd;
    bus.lsu_valid = lv;
    bus.lsu_a3    = 5'(la3);
    bus.lsu_wd    = lwd;
    bus.q_a1      = 5'(qa1);
    bus.q_a2      = 5'(qa2);
    @(negedge clk);
    alu_wr = awe && (aa3 != 0);
    ready  = !rst && (m_q.size() < DEPTH);
    bypass = 1'b0;
`ifdef WB_BYPASS_EN
    bypass = lv && ready && (m_q.size() == 0) && !alu_wr && (la3 != 0);
`endif
    pop  = 1'b0;
    e_we = 1'b0;
    e_a3 = 0;
    e_wd = 0;
    if (alu_wr) begin
      e_we = 1'b1; e_a3 = aa3; e_wd = awd;
    end else if (bypass) begin
      e_we = 1'b1; e_a3 = la3; e_wd = lwd;
    end else if (!rst && (m_q.size() > 0)) begin
      pop = 1'b1; e_we = m_q[0].valid; e_a3 = m_q[0].a3; e_wd = m_q[0].wd;
    end
    b1 = 1'b0;
    b2 = 1'b0;
    foreach (m_q[i]) begin
      if (m_q[i].valid && (qa1 != 0) && (m_q[i].a3 == qa1)) b1 = 1'b1;
      if (m_q[i].valid && (qa2 != 0) && (m_q[i].a3 == qa2)) b2 = 1'b1;
    end
    chk("we3", 64'(bus.WE3), 64'(e_we));
    if (e_we) begin
      chk("a3", 64'(bus.A3), 64'(e_a3));
      chk("wd3", 64'(bus.WD3), 64'(e_wd));
    end
    chk("lsu_ready", 64'(bus.lsu_ready), 64'(ready));
    chk("busy1", 64'(bus.busy1), 64'(b1));
    chk("busy2", 64'(bus.busy2), 64'(b2));
    if (bus.WE3 === 1'b1) begin
      chk("a3_nonzero", 64'(bus.A3 == 5'd0), 64'd0);
      dut_rf[int'(bus.A3)] = bus.WD3;
    end
    if (rst) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (alu_wr) begin
        foreach (m_q[i]) if (m_q[i].a3 == aa3) m_q[i].valid = 1'b0;
      end
      if (lv && ready && (la3 != 0) && !bypass) begin
        m_q.push_back('{valid: !(alu_wr && (la3 == aa3)), a3: la3, wd: lwd});
      end
    end
    if (e_we) m_rf[e_a3] = e_wd;
    accepted = lv && ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input int unsigned qa1, input int unsigned qa2);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, qa1, qa2, acc);
  endtask

  initial begin
    bit          acc;
    int unsigned li;
    int          guard;
    int unsigned n_acc;
    for (int r = 0; r < 32; r++) begin
      m_rf[r]   = 0;
      dut_rf[r] = 0;
    end

    // Reset, then idle.
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0, acc);
    step(1'b1, 1'b0, 0, 0, 1'b1, 3, 'h33, 0, 0, acc);
    idle(3, 1, 2);

    // Single LSU result to r5.
    step(1'b0, 1'b0, 0, 0, 1'b1, 5, 'hDEADBEEF, 5, 0, acc);
    idle(3, 5, 5);
    chk("rf_r5", 64'(dut_rf[5]), 64'hDEADBEEF);

    // ALU back-to-back r1..r8 while the LSU offers r10..r15.
    li    = 10;
    n_acc = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, k + 1, 'h100 + k, li <= 15, li, 'hA00 + li, 10, 13, acc);
      if (acc) begin
        li++;
        n_acc++;
      end
    end
    chk("accepted_during_alu", 64'(n_acc), 64'd4);
    guard = 0;
    while (li <= 15 && guard < 20) begin
      step(1'b0, 1'b0, 0, 0, 1'b1, li, 'hA00 + li, 10, 15, acc);
      if (acc) li++;
      guard++;
    end
    chk("drain_bound", 64'(li), 64'd16);
    idle(6, 14, 15);
    for (int r = 10; r <= 15; r++) chk("rf_drain", 64'(dut_rf[r]), 64'('hA00 + r));

    // WAW kill: queued r7=0x11 is overtaken by ALU r7=0x22.
    step(1'b0, 1'b1, 3, 'h3333, 1'b1, 7, 'h11, 7, 0, acc);
    step(1'b0, 1'b1, 7, 'h22, 1'b0, 0, 0, 7, 0, acc);
    idle(3, 7, 0);
    chk("rf_r7_kill", 64'(dut_rf[7]), 64'h22);

    // Register 0 from both sources.
    step(1'b0, 1'b1, 0, 'h55, 1'b1, 0, 'h66, 0, 0, acc);
    chk("r0_handshake", 64'(acc), 64'd1);
    idle(2, 0, 0);

    // Fill the queue, then reset: nothing queued may ever be written.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 20, 'h2000 + k, 1'b1, 21 + k, 'hBAD0 + k, 21, 24, acc);
    end
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 21, 24, acc);
    idle(6, 22, 23);
    for (int r = 21; r <= 24; r++) chk("rf_discarded", 64'(dut_rf[r]), 64'd0);

    // Random traffic over a narrow register range to provoke kills and busy hits.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom,
           $urandom_range(0, 4) < 3, $urandom_range(0, 7), $urandom,
           $urandom_range(0, 7), $urandom_range(0, 7), acc);
    end
    idle(DEPTH + 2, 0, 0);

    for (int r = 0; r < 32; r++) chk("rf_final", 64'(dut_rf[r]), 64'(m_rf[r]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
